// File: rtl/fp_mul_flag_pipe_if.sv
// Bus bundle for the FP multiplier flag pipeline: input beat, output flags and sticky status.
// The master side is the producer/consumer around the pipeline; the slave side is the pipeline itself.
interface fp_mul_flag_pipe_if #(
  parameter int EW = 8,
  parameter int MW = 23
);
  logic          in_valid;
  logic          in_ready;
  logic [EW-1:0] a_exp;
  logic [MW-1:0] a_man;
  logic [EW-1:0] b_exp;
  logic [MW-1:0] b_man;
  logic          sign;
  logic [EW+1:0] prod_exp;
  logic          man_ones;
  logic [2:0]    lsb_grs;
  logic [1:0]    rmode;
  logic          out_valid;
  logic          out_ready;
  logic [8:0]    out_flags;
  logic [3:0]    status;
  logic          status_clr;

  modport master (
    output in_valid, a_exp, a_man, b_exp, b_man, sign, prod_exp, man_ones,
           lsb_grs, rmode, out_ready, status_clr,
    input  in_ready, out_valid, out_flags, status
  );

  modport slave (
    input  in_valid, a_exp, a_man, b_exp, b_man, sign, prod_exp, man_ones,
           lsb_grs, rmode, out_ready, status_clr,
    output in_ready, out_valid, out_flags, status
  );
endinterface

// File: rtl/fp_mul_flag_pipe.sv
// Two-stage special-case / exception flag generator running beside the FP mantissa multiplier.
// Stage 1 classifies operands and picks the rounding increment; stage 2 resolves flags and status.
module fp_mul_flag_pipe #(
  parameter int EW  = 8,
  parameter int MW  = 23,
  parameter bit DAZ = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  fp_mul_flag_pipe_if.slave bus
);

  typedef struct packed {
    logic zero;
    logic sub;
    logic inf;
    logic nan;
    logic snan;
  } op_class_t;

  localparam logic signed [EW+1:0] EXP_LIMIT = (EW+2)'((1 << EW) - 1);
  localparam logic signed [EW+1:0] EXP_ZERO  = '0;

  // With DAZ a subnormal operand behaves exactly like a zero of the same sign.
  function automatic op_class_t classify(input logic [EW-1:0] e, input logic [MW-1:0] m);
    op_class_t c;
    logic ez, eh, mz;
    ez     = ~|e;
    eh     = &e;
    mz     = ~|m;
    c.zero = ez & (mz | DAZ);
    c.sub  = ez & ~mz & ~DAZ;
    c.inf  = eh & mz;
    c.nan  = eh & ~mz;
    c.snan = eh & ~mz & ~m[MW-1];
    return c;
  endfunction

  logic          adv;
  logic          handshake;

  op_class_t     a_cls_d;
  op_class_t     b_cls_d;
  logic          rnd_inc_d;
  logic          lsb_bit;
  logic          guard_bit;
  logic          sticky_bit;

  logic          s1_valid;
  op_class_t     s1_a;
  op_class_t     s1_b;
  logic          s1_rnd_inc;
  logic          s1_inexact_raw;
  logic [EW+1:0] s1_prod_exp;
  logic          s1_man_ones;

  logic          res_nan;
  logic          invalid;
  logic          res_inf;
  logic          res_zero;
  logic          res_sub;
  logic          special;
  logic          round_up;
  logic          overflow;
  logic          underflow;
  logic          inexact;
  logic [EW+1:0] e_fin;
  logic [8:0]    flags_d;

  logic          out_valid_q;
  logic [8:0]    flags_q;
  logic [3:0]    status_q;
  logic [3:0]    status_new;

  assign adv       = ~out_valid_q | bus.out_ready;
  assign handshake = out_valid_q & bus.out_ready;

  assign bus.in_ready  = adv;
  assign bus.out_valid = out_valid_q;
  assign bus.out_flags = flags_q;
  assign bus.status    = status_q;

  assign lsb_bit    = bus.lsb_grs[2];
  assign guard_bit  = bus.lsb_grs[1];
  assign sticky_bit = bus.lsb_grs[0];

  always_comb begin
    a_cls_d   = classify(bus.a_exp, bus.a_man);
    b_cls_d   = classify(bus.b_exp, bus.b_man);
    rnd_inc_d = 1'b0;
    case (bus.rmode)
      2'b00:   rnd_inc_d = guard_bit & (lsb_bit | sticky_bit);
      2'b01:   rnd_inc_d = 1'b0;
      2'b10:   rnd_inc_d = ~bus.sign & (guard_bit | sticky_bit);
      default: rnd_inc_d = bus.sign & (guard_bit | sticky_bit);
    endcase
  end

  // Special results suppress every rounding-related flag; only finite products see e_fin.
  always_comb begin
    res_nan   = s1_a.nan | s1_b.nan | (s1_a.zero & s1_b.inf) | (s1_a.inf & s1_b.zero);
    invalid   = s1_a.snan | s1_b.snan | (s1_a.zero & s1_b.inf) | (s1_a.inf & s1_b.zero);
    res_inf   = ~res_nan & (s1_a.inf | s1_b.inf);
    res_zero  = ~res_nan & ~res_inf & (s1_a.zero | s1_b.zero);
    special   = res_nan | res_inf | res_zero;
    res_sub   = ~special & (s1_a.sub | s1_b.sub);
    e_fin     = s1_prod_exp + (EW+2)'(s1_rnd_inc & s1_man_ones);
    round_up  = ~special & s1_rnd_inc;
    overflow  = ~special & ($signed(e_fin) >= EXP_LIMIT);
    underflow = ~special & ($signed(e_fin) <= EXP_ZERO);
    inexact   = ~special & (s1_inexact_raw | overflow);
    flags_d   = '0;
    if (s1_valid) begin
      flags_d = {invalid, res_nan, res_inf, res_zero, res_sub,
                 round_up, overflow, underflow, inexact};
    end
  end

  assign status_new = {flags_q[8], flags_q[2], flags_q[1], flags_q[0]};

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid       <= 1'b0;
      s1_a           <= '0;
      s1_b           <= '0;
      s1_rnd_inc     <= 1'b0;
      s1_inexact_raw <= 1'b0;
      s1_prod_exp    <= '0;
      s1_man_ones    <= 1'b0;
      out_valid_q    <= 1'b0;
      flags_q        <= '0;
    end else if (adv) begin
      s1_valid       <= bus.in_valid;
      s1_a           <= a_cls_d;
      s1_b           <= b_cls_d;
      s1_rnd_inc     <= rnd_inc_d;
      s1_inexact_raw <= guard_bit | sticky_bit;
      s1_prod_exp    <= bus.prod_exp;
      s1_man_ones    <= bus.man_ones;
      out_valid_q    <= s1_valid;
      flags_q        <= flags_d;
    end
  end

  // A clear coinciding with a handshake keeps only the flags of the beat leaving now.
  always_ff @(posedge clk) begin
    if (!rst) begin
      status_q <= '0;
    end else if (handshake) begin
      status_q <= (bus.status_clr ? 4'b0000 : status_q) | status_new;
    end else if (bus.status_clr) begin
      status_q <= '0;
    end
  end

endmodule

// File: doc/fp_mul_flag_pipe.md
Name: fp_mul_flag_pipe

Overview:
- Parametrised, pipelined special-case and exception flag generator for the FP multiplier.
- Classifies both operands (zero / subnormal / normal / inf / qNaN / sNaN) and resolves the special result.
- Computes rounding increment per rounding mode and detects overflow/underflow including rounding carry.
- Accumulates IEEE-style sticky status. Sits beside the mantissa multiplier; valid/ready elastic, 2-cycle latency.

Parameters:
EW, 8, exponent width
MW, 23, stored mantissa width (hidden bit excluded)
DAZ, 0, 1 = subnormal operands treated as zero (res_sub never set)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous reset, active-low
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid & in_ready
a_exp  in  EW  operand A biased exponent
a_man  in  MW  operand A mantissa
b_exp  in  EW  operand B biased exponent
b_man  in  MW  operand B mantissa
sign  in  1  product sign
prod_exp  in  EW+2  pre-round biased product exponent, two's complement
man_ones  in  1  retained product mantissa is all ones
lsb_grs  in  3  {lsb, guard, sticky}; sticky is the OR of all discarded bits below guard
rmode  in  2  00 RNE, 01 RTZ, 10 toward +inf, 11 toward -inf
out_valid  out  1  result valid
out_ready  in  1  downstream accepts
out_flags  out  9  {invalid, res_nan, res_inf, res_zero, res_sub, round_up, overflow, underflow, inexact}
status  out  4  sticky {invalid, overflow, underflow, inexact}
status_clr  in  1  clear sticky status

Behaviour:
- Reset (rst==0 at clk edge): both stage valids, out_valid, out_flags and status go to 0; in-flight beats are discarded. in_ready is 1 on the first cycle after reset.
- Advance: adv = ~out_valid | out_ready.
  - in_ready = adv (global stall; no skid buffer).
  - When adv: S1 <= input beat; S2/out <= S1; valids shift along with the data.
  - When ~adv, all stage registers hold. Latency is exactly 2 cycles when out_ready stays high; throughput is 1 beat/cycle.
- S1 (registered per operand X in {A,B}):
  - ez = exp all-zero; eh = exp all-ones; mz = man all-zero.
  - Classes: zero = ez&mz; sub = ez&~mz; inf = eh&mz; nan = eh&~mz; snan = nan & ~man[MW-1].
  - If DAZ=1, sub is folded into zero.
  - Also registers: rnd_inc per rmode.
    - RNE: g&(l|s).
    - RTZ: 0.
    - +inf: ~sign&(g|s).
    - -inf: sign&(g|s).
  - Also registers inexact_raw = g|s, prod_exp and man_ones.
- S2 (registered to out_flags):
  - res_nan = An|Bn|(Az&Bi)|(Ai&Bz).
  - invalid = Asn|Bsn|(Az&Bi)|(Ai&Bz).
  - res_inf = ~res_nan&(Ai|Bi).
  - res_zero = ~res_nan&~res_inf&(Az|Bz).
  - res_sub = ~special & (As|Bs); special = res_nan|res_inf|res_zero.
  - Finite path (all of res_nan, res_inf, res_zero = 0):
    - round_up = rnd_inc.
    - e_fin = prod_exp + (rnd_inc&man_ones), computed at EW+2 bits, signed.
    - overflow = e_fin >= 2^EW-1 (non-negative).
    - underflow = e_fin <= 0.
    - inexact = inexact_raw | overflow.
  - Special path: round_up, overflow, underflow and inexact are all 0.
- Status:
  - On output handshake (out_valid&out_ready): status <= (status_clr ? 0 : status) | {invalid, overflow, underflow, inexact}.
  - Without a handshake: status_clr clears status to 0; otherwise status holds.
  - A handshake in the same cycle as status_clr therefore leaves only the new beat's flags.
- out_flags are stable while out_valid&~out_ready.
- in_valid=0 while adv inserts a bubble; it never alters status.

Test Plan:
- Operands A=inf (a_exp=8'hFF, a_man=0), B=zero (b_exp=0, b_man=0), out_ready=1 -> two cycles later out_valid=1, out_flags=9'b1_1000_0000 (invalid, res_nan); status=4'b1000.
- Finite normal operands, RNE, prod_exp=10'd100:
  - lsb_grs=3'b010 -> round_up=0, inexact=1.
  - lsb_grs=3'b110 -> round_up=1.
  - rmode=RTZ with 3'b111 -> round_up=0, inexact=1.
- prod_exp=10'd254, man_ones=1, lsb_grs=3'b011, RNE -> e_fin=255, overflow=1, inexact=1.
  - Same with man_ones=0 -> overflow=0.
- prod_exp=10'h3FF (-1) -> underflow=1; prod_exp=0 -> underflow=1; prod_exp=1 with lsb_grs=0 -> underflow=0, inexact=0.
- Three beats offered back-to-back, out_ready=0 for 4 cycles, then 1:
  - in_ready drops once both stages are full.
  - All three beats emerge in order with no loss or duplication; out_flags are held stable while stalled.
- status_clr asserted on the same cycle as a handshake of a qNaN×1.0 beat -> status=4'b0000 (qNaN raises none).
  - With an sNaN beat -> status=4'b1000.
  - rst=0 mid-stream for one cycle -> out_valid=0 and status=0 next cycle; in-flight beats are gone.
